addressing_sequencer: RTL and testbench

Multi-cycle control FSM for the addressing unit of the FIR filter processor. It drives the `AddressingUnit` select lines (`ResetPC`, `PCplusI`, `PCplus1`, `RplusI`, `Rplus0`) and `PCenable` through fetch, increment, decode and memory-access phases. It also handshakes with data/instruction memory through `ReadMem`/`WriteMem`/`MemReady`. It sits beside `AddressingUnit` and is the only block that sources its control inputs.

---
 rtl/addressing_sequencer.sv | 156 +++++++++++++++
 tb/tb_addressing_sequencer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/addressing_sequencer.sv
// Control FSM for the FIR processor addressing unit: fetch/increment/decode/memory phases.
// Optional memory-wait timeout enabled by defining ADDRSEQ_MEMTIMEOUT_EN.
module addressing_sequencer #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] Opcode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       ResetPC,
   output logic       PCplusI,
   output logic       PCplus1,
   output logic       RplusI,
   output logic       Rplus0,
   output logic       PCenable,
   output logic       ReadMem,
   output logic       WriteMem,
   output logic       IRload,
   output logic       RegLoad,
   output logic       ExecEn,
   output logic       Halted,
   output logic       Fault,
   output logic [2:0] State
);

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_INCR   = 3'd2,
      S_DECODE = 3'd3,
      S_MEMRD  = 3'd4,
      S_MEMWR  = 3'd5,
      S_HALTED = 3'd6,
      S_FAULT  = 3'd7
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_wait_state;
   logic   w_timeout;

   assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);

`ifdef ADDRSEQ_MEMTIMEOUT_EN
   localparam logic [7:0] C_LAST = 8'(TIMEOUT - 1);
   logic [7:0] r_wait_cnt;

   // Counter restarts whenever the FSM changes state, which covers every entry into a wait state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_wait_cnt <= 8'd0;
      else if (w_next != r_state)
         r_wait_cnt <= 8'd0;
      else if (w_wait_state && !MemReady)
         r_wait_cnt <= r_wait_cnt + 8'd1;
   end

   assign w_timeout = w_wait_state && !MemReady && (r_wait_cnt == C_LAST);
`else
   logic [7:0] w_unused_timeout;
   assign w_unused_timeout = 8'(TIMEOUT);
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_RST;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      ResetPC  = 1'b0;
      PCplusI  = 1'b0;
      PCplus1  = 1'b0;
      RplusI   = 1'b0;
      Rplus0   = 1'b0;
      PCenable = 1'b0;
      ReadMem  = 1'b0;
      WriteMem = 1'b0;
      IRload   = 1'b0;
      RegLoad  = 1'b0;
      ExecEn   = 1'b0;
      Halted   = 1'b0;
      Fault    = 1'b0;
      case (r_state)
         S_RST: begin
            ResetPC  = 1'b1;
            PCenable = 1'b1;
            w_next   = S_FETCH;
         end
         S_FETCH: begin
            ReadMem = 1'b1;
            if (MemReady) begin
               IRload = 1'b1;
               w_next = S_INCR;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end
         end
         S_INCR: begin
            PCplus1  = 1'b1;
            PCenable = 1'b1;
            w_next   = S_DECODE;
         end
         S_DECODE: begin
            w_next = S_FETCH;
            case (Opcode)
               4'b0000: w_next = S_FETCH;
               4'b0001: w_next = S_HALTED;
               4'b0010: w_next = S_MEMRD;
               4'b0011: w_next = S_MEMWR;
               4'b0100: begin
                  PCplusI  = 1'b1;
                  PCenable = 1'b1;
               end
               4'b0101: begin
                  PCplusI  = Zero;
                  PCenable = Zero;
               end
               4'b0110: begin
                  Rplus0   = 1'b1;
                  PCenable = 1'b1;
               end
               default: ExecEn = 1'b1;
            endcase
         end
         S_MEMRD: begin
            RplusI  = 1'b1;
            ReadMem = 1'b1;
            if (MemReady) begin
               RegLoad = 1'b1;
               w_next  = S_FETCH;
            end else if (w_timeout) begin
               w_next = S_FAULT;
            end
         end
         S_MEMWR: begin
            Rplus0   = 1'b1;
            WriteMem = 1'b1;
            if (MemReady)
               w_next = S_FETCH;
            else if (w_timeout)
               w_next = S_FAULT;
         end
         S_HALTED: Halted = 1'b1;
         S_FAULT:  Fault  = 1'b1;
         default:  w_next = S_RST;
      endcase
   end

   assign State = r_state;

endmodule

// File: tb/tb_addressing_sequencer.sv
// Directed, table-driven bench for addressing_sequencer; timeout checks need ADDRSEQ_MEMTIMEOUT_EN.
module tb_addressing_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] Opcode = 4'd0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       ResetPC, PCplusI, PCplus1, RplusI, Rplus0, PCenable;
   logic       ReadMem, WriteMem, IRload, RegLoad, ExecEn, Halted, Fault;
   logic [2:0] State;

`ifdef ADDRSEQ_MEMTIMEOUT_EN
   localparam int P_TIMEOUT = 4;
`else
   localparam int P_TIMEOUT = 16;
`endif

   addressing_sequencer #(.TIMEOUT(P_TIMEOUT)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1), .RplusI(RplusI),
      .Rplus0(Rplus0), .PCenable(PCenable), .ReadMem(ReadMem), .WriteMem(WriteMem),
      .IRload(IRload), .RegLoad(RegLoad), .ExecEn(ExecEn), .Halted(Halted),
      .Fault(Fault), .State(State)
   );

   always #5 clk = ~clk;

   // Output bit masks, in the order of w_outs below.
   localparam logic [12:0] RPC = 13'h1000, PCI = 13'h0800, PC1 = 13'h0400, RPI = 13'h0200,
                           RP0 = 13'h0100, PCE = 13'h0080, RD  = 13'h0040, WR  = 13'h0020,
                           IRL = 13'h0010, RGL = 13'h0008, EXE = 13'h0004, HLT = 13'h0002,
                           FLT = 13'h0001, NONE = 13'h0000;

   logic [12:0] w_outs;
   assign w_outs = {ResetPC, PCplusI, PCplus1, RplusI, Rplus0, PCenable, ReadMem, WriteMem,
                    IRload, RegLoad, ExecEn, Halted, Fault};

   typedef struct {
      logic        rst;
      logic [3:0]  op;
      logic        z;
      logic        mr;
      logic [2:0]  st;
      logic [12:0] outs;
   } vec_t;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [2:0] st, input logic [12:0] outs);
      n_vec++;
      if (State !== st || w_outs !== outs) begin
         n_err++;
         $display("FAIL %s: got State=%0d outs=%013b, want State=%0d outs=%013b",
                  name, State, w_outs, st, outs);
      end
   endtask

   task automatic drive(input logic r, input logic [3:0] op, input logic z, input logic mr);
      @(negedge clk);
      reset = r; Opcode = op; Zero = z; MemReady = mr;
      #1;
   endtask

   vec_t vt[$];

   task automatic add(input logic r, input logic [3:0] op, input logic z, input logic mr,
                      input logic [2:0] st, input logic [12:0] outs);
      vec_t v;
      v.rst = r; v.op = op; v.z = z; v.mr = mr; v.st = st; v.outs = outs;
      vt.push_back(v);
   endtask

   task automatic add_fid(input logic [3:0] op);
      add(0, op, 0, 1, 3'd1, RD | IRL);
      add(0, op, 0, 1, 3'd2, PC1 | PCE);
   endtask

   initial begin
      // reset and first fetch
      add(1, 4'h0, 0, 1, 3'd0, RPC | PCE);
      add(0, 4'h0, 0, 1, 3'd0, RPC | PCE);
      add_fid(4'h0); add(0, 4'h0, 0, 1, 3'd3, NONE);
      // LDR with two wait cycles, then a fetch wait
      add_fid(4'h2); add(0, 4'h2, 0, 1, 3'd3, NONE);
      add(0, 4'h2, 0, 0, 3'd4, RPI | RD);
      add(0, 4'h2, 0, 0, 3'd4, RPI | RD);
      add(0, 4'h2, 0, 1, 3'd4, RPI | RD | RGL);
      add(0, 4'h5, 0, 0, 3'd1, RD);
      // BRZ taken / not taken
      add_fid(4'h5); add(0, 4'h5, 1, 1, 3'd3, PCI | PCE);
      add_fid(4'h5); add(0, 4'h5, 0, 1, 3'd3, NONE);
      // JMPR
      add_fid(4'h6); add(0, 4'h6, 0, 1, 3'd3, RP0 | PCE);
      // STR with one wait
      add_fid(4'h3); add(0, 4'h3, 0, 1, 3'd3, NONE);
      add(0, 4'h3, 0, 0, 3'd5, RP0 | WR);
      add(0, 4'h3, 0, 1, 3'd5, RP0 | WR);
      // JMP, ALU ops, HALT
      add_fid(4'h4); add(0, 4'h4, 1, 1, 3'd3, PCI | PCE);
      add_fid(4'h7); add(0, 4'h7, 0, 1, 3'd3, EXE);
      add_fid(4'hF); add(0, 4'hF, 0, 1, 3'd3, EXE);
      add_fid(4'h1); add(0, 4'h1, 0, 1, 3'd3, NONE);
      add(0, 4'h1, 0, 1, 3'd6, HLT);

      for (int i = 0; i < vt.size(); i++) begin
         drive(vt[i].rst, vt[i].op, vt[i].z, vt[i].mr);
         check($sformatf("vec%0d", i), vt[i].st, vt[i].outs);
      end

      // HALTED holds for 20 cycles regardless of MemReady
      for (int i = 0; i < 20; i++) begin
         drive(0, 4'h0, 0, i[0]);
         check($sformatf("halt_hold%0d", i), 3'd6, HLT);
      end

      // async reset pulse mid-cycle from HALTED
      @(posedge clk); #2 reset = 1'b1; #1;
      check("halt_async_rst", 3'd0, RPC | PCE);
      drive(0, 4'h0, 0, 0);
      check("rst_release_hold", 3'd0, RPC | PCE);
      drive(0, 4'h0, 0, 0);
      check("fetch_wait", 3'd1, RD);

      // reset during a pending fetch drops ReadMem at once
      @(posedge clk); #2 reset = 1'b1; #1;
      check("fetch_async_rst", 3'd0, RPC | PCE);
      drive(0, 4'h0, 0, 0);

`ifdef ADDRSEQ_MEMTIMEOUT_EN
      for (int i = 0; i < 4; i++) begin
         drive(0, 4'h0, 0, 0);
         check($sformatf("to_wait%0d", i), 3'd1, RD);
      end
      drive(0, 4'h0, 0, 1);
      check("to_fault", 3'd7, FLT);
      drive(0, 4'h0, 0, 1);
      check("to_fault_sticky", 3'd7, FLT);
      drive(1, 4'h0, 0, 0);
      check("to_rst", 3'd0, RPC | PCE);
      drive(0, 4'h0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 4'h0, 0, 0);
         check($sformatf("to_rerun%0d", i), 3'd1, RD);
      end
      drive(0, 4'h0, 0, 1);
      check("to_ready_wins", 3'd1, RD | IRL);
      drive(0, 4'h0, 0, 1);
      check("to_incr", 3'd2, PC1 | PCE);
`else
      for (int i = 0; i < 24; i++) begin
         drive(0, 4'h0, 0, 0);
         check($sformatf("nowait_limit%0d", i), 3'd1, RD);
      end
      drive(0, 4'h0, 0, 1);
      check("late_ready", 3'd1, RD | IRL);
      drive(0, 4'h0, 0, 1);
      check("late_incr", 3'd2, PC1 | PCE);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
